// File: rtl/lcd_pkg.sv
// Shared types and constants for the character LCD sequencer.
// Contents: FSM state enum, bit positions inside the packed 32-bit LCD word,
// HD44780 command bytes used by the init table, and the long-wait classifier.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_EN,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  // Packed LCD word layout
  localparam int unsigned LCD_DATA_LSB = 0;
  localparam int unsigned LCD_RW_BIT   = 8;
  localparam int unsigned LCD_RS_BIT   = 9;
  localparam int unsigned LCD_EN_BIT   = 10;
  localparam int unsigned LCD_ON_BIT   = 31;

  // Commands used by the power-on init table
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int unsigned INIT_LEN = 6;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution delay.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data >= 8'h01) && (data <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Request handshake between a byte producer and the LCD sequencer.
// Signals: valid (request present), rs (0 = command, 1 = data), data (byte),
// ready (sequencer can accept this cycle).
// Modports: master drives the request, slave (the sequencer) drives ready.
interface lcd_ctrl_if;
  logic       valid;
  logic       rs;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output rs, output data, input ready);
  modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_init_rom.sv
// Power-on initialisation table for the LCD, combinational lookup.
// Ports: idx_i - table index (0..INIT_LEN-1), byte_o - command byte
// (0 for out-of-range indices).
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      3'd0, 3'd1, 3'd2: byte_o = FUNC_SET_8B2L;
      3'd3:             byte_o = DISP_ON;
      3'd4:             byte_o = CLEAR;
      3'd5:             byte_o = ENTRY_INC;
      default:          byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD sequencer, clocked at 1 MHz (1 cycle = 1 us).
// Runs the power-on init sequence, then writes command/data bytes accepted on
// the request handshake, producing RS/RW/EN/DATA timing and execution delays.
// Ports:
//   i_clk       - 1 MHz clock
//   i_reset     - asynchronous active-low reset
//   req         - request handshake (valid/rs/data in, ready out)
//   o_init_done - init sequence completed (sticky until reset)
//   o_lcd       - packed LCD word: DATA[7:0], RW[8], RS[9], EN[10], ON[31]
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP   = 15000,
  parameter int unsigned T_SETUP     = 1,
  parameter int unsigned T_EN        = 1,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned T_EXEC      = 40,
  parameter int unsigned T_EXEC_LONG = 1640
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lcd_ctrl_if.slave   req,
  output logic        o_init_done,
  output logic [31:0] o_lcd
);

  localparam int unsigned CntMax0 = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned CntMax  = (CntMax0 > T_EXEC) ? CntMax0 : T_EXEC;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Counter runs 0..N-1 in each state, so a state lasts exactly N cycles.
  localparam cnt_t PwrLast   = cnt_t'(T_POWERUP - 1);
  localparam cnt_t SetupLast = cnt_t'(T_SETUP - 1);
  localparam cnt_t EnLast    = cnt_t'(T_EN - 1);
  localparam cnt_t HoldLast  = cnt_t'(T_HOLD - 1);
  localparam cnt_t ExecLast  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LongLast  = cnt_t'(T_EXEC_LONG - 1);

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       init_done_q, init_done_d;
  logic       ready_q, en_q, on_q;

  logic [2:0] rom_idx;
  logic [7:0] rom_byte;
  cnt_t       wait_last;

  // Entry 0 is loaded leaving power-up; afterwards the next entry is prefetched.
  assign rom_idx = (state_q == S_PWRUP) ? 3'd0 : idx_q + 3'd1;

  lcd_init_rom u_rom (
    .idx_i  (rom_idx),
    .byte_o (rom_byte)
  );

  assign wait_last = is_long_cmd(rs_q, data_q) ? LongLast : ExecLast;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == PwrLast) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = rom_byte;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (req.valid && ready_q) begin
          state_d = S_SETUP;
          rs_d    = req.rs;
          data_d  = req.data;
        end
      end
      S_SETUP: begin
        if (cnt_q == SetupLast) begin
          state_d = S_EN;
          cnt_d   = '0;
        end
      end
      S_EN: begin
        if (cnt_q == EnLast) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HoldLast) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!init_done_q && (idx_q != 3'(INIT_LEN - 1))) begin
            state_d = S_SETUP;
            idx_d   = idx_q + 3'd1;
            rs_d    = 1'b0;
            data_d  = rom_byte;
          end else begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      // Registered from next state so outputs line up with the state register.
      ready_q     <= (state_d == S_IDLE) && init_done_d;
      en_q        <= (state_d == S_EN);
      on_q        <= 1'b1;
    end
  end

  assign req.ready   = ready_q;
  assign o_init_done = init_done_q;

  always_comb begin
    o_lcd                         = '0;
    o_lcd[LCD_DATA_LSB +: 8]      = data_q;
    o_lcd[LCD_RW_BIT]             = 1'b0;
    o_lcd[LCD_RS_BIT]             = rs_q;
    o_lcd[LCD_EN_BIT]             = en_q;
    o_lcd[LCD_ON_BIT]             = on_q;
  end

endmodule
